controle_memoria_dados: RTL
===========================

# controle_memoria_dados

Access controller for the 64-bit LED-sequence data memory (1024 words). Arbitrates between two requesters, the sequence generator (write port) and the display/playback engine (read port), over the memory's single address/data/write-enable interface. Uses a req/ack handshake on each side and round-robin fairness. Absorbs the memory's one-cycle registered read latency, so requesters see a simple "request → ack with data" transaction.

## Interface

- bits_palavra, 64, word width (32 LEDs × 2 bits)
- end_registros, 10, address width; memory depth 2**end_registros

- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- escr_req  in  1  write request; held high with escr_end/escr_dado stable until escr_ack
- escr_end  in  end_registros  write address
- escr_dado  in  bits_palavra  write data
- escr_ack  out  1  one-cycle pulse; write committed at the end of this cycle
- leit_req  in  1  read request; held high with leit_end stable until leit_ack
- leit_end  in  end_registros  read address
- leit_ack  out  1  one-cycle pulse; leit_dado valid in this cycle
- leit_dado  out  bits_palavra  read data; holds the last read value until the next leit_ack
- mem_hab_escrita  out  1  memory write enable
- mem_endereco  out  end_registros  memory address
- mem_entrada  out  bits_palavra  memory write data
- mem_saida  in  bits_palavra  memory registered output; reflects mem_endereco one clock after the edge that sampled it
- ocupado  out  1  high whenever state ≠ OCIOSO

## Operation

- All outputs are registered. Reset value of every output is 0. State after reset is OCIOSO, or LIMPA when LIMPEZA_EN is defined.
- States:
  - LIMPA: initialization sweep; present only with the macro.
  - OCIOSO: idle.
  - ESCREVE: write in progress.
  - LE: read address presented to memory.
  - ESPERA: memory output settling.
- Transitions:
  - OCIOSO → ESCREVE when the write port is granted.
  - OCIOSO → LE when the read port is granted.
  - ESCREVE → OCIOSO.
  - LE → ESPERA.
  - ESPERA → OCIOSO.
- Arbitration in OCIOSO:
  - With one request, grant it.
  - With both requests, grant the port not served last. An internal flag, ultimo, records the last-served port.
  - After reset, ultimo = read, so the write port wins the first tie.
- Address and data are latched at grant. Input changes after grant are ignored until the transaction ends.
- Write transaction: mem_hab_escrita=1, with mem_endereco/mem_entrada set to the latched values, for exactly one cycle (ESCREVE). escr_ack is high in that same cycle.
- Read transaction: mem_hab_escrita=0 and mem_endereco set to the latched address (LE). In ESPERA, mem_saida is sampled into leit_dado, and leit_ack pulses in the following cycle.
- mem_endereco and mem_entrada hold their last values when idle. mem_hab_escrita is 0 outside ESCREVE and LIMPA.
- A req still high in the cycle after its ack counts as a new request. If a req drops while its transaction is in progress, the transaction still completes and the ack is still issued.
- Address wrap: 2**end_registros−1 is a valid address, with no wrap logic on requester addresses.

## Timing

- Write:
  - Grant in OCIOSO at cycle 0.
  - Cycle 1 (ESCREVE): mem_hab_escrita=1 and escr_ack=1; the memory stores the word at the end of cycle 1.
  - Cycle 2: back in OCIOSO.
  - Peak write rate is 1 per 2 cycles.
- Read:
  - Grant at cycle 0.
  - Cycle 1: LE.
  - Cycle 2: ESPERA; mem_saida is valid.
  - Cycle 3: leit_ack=1 with leit_dado valid, and the state is OCIOSO, so a new grant can be made in cycle 3.
  - Request-to-ack latency is 3 cycles.
- Back-to-back alternating requests: write, read, write… with no idle cycles beyond those listed above.
- Reset asserted mid-transaction:
  - The transaction is aborted immediately (asynchronously), with mem_hab_escrita=0 and no ack issued.
  - Requesters must reissue after reset.
- The memory's own reset is active-high; the top level drives it with ~reset.

## Configuration

- LIMPEZA_EN defined:
  - After reset release, the block enters LIMPA and writes 0 to every address from 0 to 2**end_registros−1, one address per cycle. mem_hab_escrita stays 1 and mem_endereco increments each cycle.
  - This takes 1024 cycles at default parameters.
  - ocupado=1 throughout. Requests are held pending with no acks.
  - The block moves to OCIOSO in the cycle after address 1023 is written.
- LIMPEZA_EN undefined: the LIMPA state is not built. The block enters OCIOSO directly after reset, and memory contents rely on the memory's own reset.

## Test plan

- Write 0xA5A5_0000_FFFF_1234 to address 5, then read address 5 → escr_ack in cycle 1, leit_ack 3 cycles after the read grant, leit_dado=0xA5A5_0000_FFFF_1234.
- escr_req and leit_req rise together right after reset → write is granted first, then read. With both held high, grants alternate write, read, write across 3 transactions.
- Write to address 1023, then read address 1023 → data correct, with no alias to address 0.
- Change escr_end from 7 to 9 in the cycle after grant → the write lands at address 7; address 9 is unchanged.
- Assert reset during ESPERA of a read → leit_ack never pulses, all outputs read 0, and ocupado=0 (macro off).
- LIMPEZA_EN defined, with leit_req at address 3 held from reset release → ocupado high for 1024 cycles, mem_endereco sweeps 0..1023, then leit_ack pulses with leit_dado=0.

Source files
------------

// File: rtl/controle_memoria_dados.sv
// controle_memoria_dados: access controller for the LED-sequence data memory.
// Arbitrates a write requester (sequence generator) and a read requester
// (playback engine) over one address/data/write-enable memory port, with
// round-robin fairness on ties and the one-cycle registered read absorbed.
// Build macro LIMPEZA_EN: after reset, zero-fill every memory address before
// serving any request.
//
// Handshake: a requester raises *_req with its address (and data) stable and
// holds it until its *_ack, which pulses for exactly one cycle. A req seen in
// the ack cycle itself is not a new request; a req still high in the cycle
// after the ack is a new request. A req dropped mid-transaction does not abort
// it: the transaction completes and the ack is still issued.
module controle_memoria_dados #(
  parameter int bits_palavra  = 64,
  parameter int end_registros = 10
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     escr_req,
  input  logic [end_registros-1:0] escr_end,
  input  logic [bits_palavra-1:0]  escr_dado,
  output logic                     escr_ack,
  input  logic                     leit_req,
  input  logic [end_registros-1:0] leit_end,
  output logic                     leit_ack,
  output logic [bits_palavra-1:0]  leit_dado,
  output logic                     mem_hab_escrita,
  output logic [end_registros-1:0] mem_endereco,
  output logic [bits_palavra-1:0]  mem_entrada,
  input  logic [bits_palavra-1:0]  mem_saida,
  output logic                     ocupado
);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    ESCREVE = 3'd1,
    LE      = 3'd2,
    ESPERA  = 3'd3
`ifdef LIMPEZA_EN
    , LIMPA = 3'd4
`endif
  } estado_t;

`ifdef LIMPEZA_EN
  localparam logic [end_registros-1:0] END_MAX = '1;
`endif

  estado_t                  estado_q, estado_d;
  logic                     ultimo_q, ultimo_d;  // 1: read served last, 0: write
  logic                     escr_ack_q, escr_ack_d;
  logic                     leit_ack_q, leit_ack_d;
  logic [bits_palavra-1:0]  leit_dado_q, leit_dado_d;
  logic                     hab_q, hab_d;
  logic [end_registros-1:0] end_q, end_d;
  logic [bits_palavra-1:0]  entrada_q, entrada_d;
  logic                     ocupado_q, ocupado_d;

  // Read request qualified so the ack cycle does not re-trigger a grant.
  logic leit_req_ef;
  logic conc_escr;
  logic conc_leit;

  // Next-state, arbitration and registered-output decode.
  always_comb begin
    estado_d    = estado_q;
    ultimo_d    = ultimo_q;
    escr_ack_d  = 1'b0;
    leit_ack_d  = 1'b0;
    leit_dado_d = leit_dado_q;
    hab_d       = 1'b0;
    end_d       = end_q;
    entrada_d   = entrada_q;
    leit_req_ef = leit_req & ~leit_ack_q;
    conc_escr   = 1'b0;
    conc_leit   = 1'b0;
    case (estado_q)
      OCIOSO: begin
        conc_escr = escr_req & (~leit_req_ef | ultimo_q);
        conc_leit = leit_req_ef & ~conc_escr;
        if (conc_escr) begin
          estado_d   = ESCREVE;
          ultimo_d   = 1'b0;
          hab_d      = 1'b1;
          end_d      = escr_end;
          entrada_d  = escr_dado;
          escr_ack_d = 1'b1;
        end else if (conc_leit) begin
          estado_d = LE;
          ultimo_d = 1'b1;
          end_d    = leit_end;
        end
      end
      ESCREVE: estado_d = OCIOSO;
      LE:      estado_d = ESPERA;
      ESPERA: begin
        estado_d    = OCIOSO;
        leit_dado_d = mem_saida;
        leit_ack_d  = 1'b1;
      end
`ifdef LIMPEZA_EN
      LIMPA: begin
        // The cycle presenting the last address ends the sweep.
        if (hab_q && (end_q == END_MAX)) begin
          estado_d = OCIOSO;
        end else begin
          hab_d     = 1'b1;
          end_d     = hab_q ? end_q + 1'b1 : '0;
          entrada_d = '0;
        end
      end
`endif
      default: estado_d = OCIOSO;
    endcase
    ocupado_d = (estado_d != OCIOSO);
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
`ifdef LIMPEZA_EN
      estado_q <= LIMPA;
`else
      estado_q <= OCIOSO;
`endif
      ultimo_q    <= 1'b1;
      escr_ack_q  <= 1'b0;
      leit_ack_q  <= 1'b0;
      leit_dado_q <= '0;
      hab_q       <= 1'b0;
      end_q       <= '0;
      entrada_q   <= '0;
      ocupado_q   <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      ultimo_q    <= ultimo_d;
      escr_ack_q  <= escr_ack_d;
      leit_ack_q  <= leit_ack_d;
      leit_dado_q <= leit_dado_d;
      hab_q       <= hab_d;
      end_q       <= end_d;
      entrada_q   <= entrada_d;
      ocupado_q   <= ocupado_d;
    end
  end

  assign escr_ack        = escr_ack_q;
  assign leit_ack        = leit_ack_q;
  assign leit_dado       = leit_dado_q;
  assign mem_hab_escrita = hab_q;
  assign mem_endereco    = end_q;
  assign mem_entrada     = entrada_q;
  assign ocupado         = ocupado_q;

endmodule
